mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised memory-access / write-back stage (pipeline stage 4) for the RISC-V core; sits between Execute and the register file / data RAM.
- Replaces the fixed-timing, delay-based store/writeback logic with a clocked valid/ready stage.
- Adds byte/halfword/word (and optional doubleword) loads and stores with byte enables, sign/zero extension, misalignment and illegal-funct3 detection, and a variable-latency load handshake with timeout.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
ADDR_W, 10, byte-address width of the data memory.
REG_ADDR_W, 5, register-file index width.
TIMEOUT, 15, maximum cycles spent in LOAD_WAIT without mem_rvalid before a fault is raised; must be at least 1.

Ports:
clk  in  1  clock; all logic on posedge.
Reset  in  1  synchronous, active-high reset.
in_valid  in  1  upstream op valid.
in_ready  out  1  stage can accept; equals (state==IDLE).
in_is_load  in  1  op is a load.
in_is_store  in  1  op is a store.
in_funct3  in  3  RISC-V width/sign code.
in_rd  in  REG_ADDR_W  destination register.
in_addr  in  ADDR_W  byte address (loads/stores).
in_data  in  XLEN  store data, or ALU result for non-memory ops.
mem_req  out  1  one-cycle memory request strobe.
mem_we  out  1  1 = write, valid with mem_req.
mem_addr  out  ADDR_W  in_addr with low log2(XLEN/8) bits cleared.
mem_be  out  XLEN/8  byte enables.
mem_wdata  out  XLEN  store data shifted to its byte lane.
mem_rdata  in  XLEN  load data, valid with mem_rvalid.
mem_rvalid  in  1  load data valid.
wb_en  out  1  register write strobe, one cycle.
wb_rd  out  REG_ADDR_W  register written.
wb_data  out  XLEN  value written.
fault  out  1  one-cycle fault pulse.
fault_code  out  2  01 misaligned, 10 load timeout, 11 illegal funct3; 00 when fault=0.

Behaviour:
Reset
- All outputs are registered and reset to 0, except in_ready, which is 1 (state IDLE).
- Timeout counter resets to 0.
- Reset asserted mid-load abandons the load: no writeback, and a late mem_rvalid is ignored.

States
- IDLE, LOAD_WAIT.
- Accept = in_valid & in_ready at posedge k. All responses below appear in cycle k+1.
- mem_req, wb_en and fault are single-cycle pulses, 0 otherwise.

Non-memory op (is_load=0, is_store=0)
- wb_en=1, wb_rd=in_rd, wb_data=in_data.
- Stay in IDLE; back-to-back ops are allowed every cycle.

Store
- mem_req=1, mem_we=1.
- mem_be and mem_wdata are set from funct3 and offset: SB 000 → 1 lane; SH 001 → 2 lanes; SW 010 → 4 lanes; SD 011 → all lanes (XLEN=64 only).
- No writeback; stay in IDLE.

Load
- mem_req=1, mem_we=0, mem_be as for a store of the same width; go to LOAD_WAIT and clear the counter.
- In LOAD_WAIT, the counter increments each cycle.
- On mem_rvalid at edge m: extract the lane, extend per funct3, and at m+1 drive wb_en=1 and return to IDLE.
- Extension by funct3: LB 000 / LH 001 / LW 010 sign-extend; LBU 100 / LHU 101 / LWU 110 zero-extend; LD 011 none. LWU and LD are legal only when XLEN=64.
- If the counter reaches TIMEOUT with no mem_rvalid: fault=1, code 10, no writeback, return to IDLE.
- mem_rvalid on the same edge the counter reaches TIMEOUT: rvalid wins, normal writeback.

Rules applied to every op
- in_rd==0: wb_en stays 0 (x0 is never written); loads are still issued and waited on.
- in_is_load & in_is_store both set: treated as a load.
- Illegal funct3 for the op type or XLEN: fault code 11, no memory request, no writeback; takes precedence over misalignment.
- Misaligned access: the address is not a multiple of the access size. Fault code 01, no memory request, no writeback.
- Any fault leaves the stage in IDLE.
- mem_rvalid outside LOAD_WAIT is ignored.

Test Plan:
- ALU op: in_data=0x0000_00A5, rd=3 → next cycle wb_en=1, wb_rd=3, wb_data=0x0000_00A5; with rd=0 → wb_en=0.
- SB, addr=0x006, data=0x0000_00C3 → mem_req=1, mem_we=1, mem_addr=0x004, mem_be=0100, mem_wdata=0x00C3_0000; no writeback.
- LB, addr=0x001, rdata=0x0000_8000 → sign-extend byte 0x80 → wb_data=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LW, addr=0x008, rvalid after 3 cycles, rdata=0xDEAD_BEEF → in_ready=0 for those cycles; one cycle after rvalid, wb_en=1, wb_data=0xDEAD_BEEF, in_ready=1.
- LH at addr=0x003 → fault=1, code 01, mem_req=0. LW with no rvalid for 15 cycles → fault, code 10, no wb_en. LD with XLEN=32 → fault, code 11.
- Reset asserted in LOAD_WAIT, then rvalid pulsed → no wb_en, in_ready=1 after reset; a following ALU op completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back pipeline stage: valid/ready accept, byte-lane loads and stores,
// sign/zero extension, misalignment and funct3 checks, and a load wait with timeout fault.
module mem_wb_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [XLEN-1:0]       in_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  fault,
    output logic [1:0]            fault_code
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [2:0]              ld_funct3;
    logic [REG_ADDR_W-1:0]   ld_rd;
    logic [OFF_W-1:0]        ld_off;

    logic                    is_load, is_store, funct3_ok, misaligned;
    logic [OFF_W-1:0]        off;
    logic [2:0]              align_mask;
    logic [NB-1:0]           be_base;
    logic [XLEN-1:0]         data_mask, store_data, shifted, load_ext;

    assign in_ready = (state == StIdle);
    assign is_load  = in_is_load;
    assign is_store = in_is_store & ~in_is_load;
    assign off      = in_addr[OFF_W-1:0];

    always_comb begin
        funct3_ok = 1'b0;
        if (is_load) begin
            unique case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
                3'b011, 3'b110:                         funct3_ok = (XLEN == 64);
                default:                                funct3_ok = 1'b0;
            endcase
        end else if (is_store) begin
            unique case (in_funct3)
                3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
                3'b011:                 funct3_ok = (XLEN == 64);
                default:                funct3_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        unique case (in_funct3[1:0])
            2'b00:   begin align_mask = 3'd0; be_base = NB'(1);  end
            2'b01:   begin align_mask = 3'd1; be_base = NB'(3);  end
            2'b10:   begin align_mask = 3'd3; be_base = NB'(15); end
            default: begin align_mask = 3'd7; be_base = '1;      end
        endcase
        misaligned = (in_addr[2:0] & align_mask) != 3'd0;
        data_mask  = '0;
        for (int i = 0; i < NB; i++) begin
            data_mask[8*i +: 8] = {8{be_base[i]}};
        end
        store_data = (in_data & data_mask) << {off, 3'b000};
    end

    // Lane extraction for the pending load, using the offset/width captured at accept.
    always_comb begin
        shifted = mem_rdata >> {ld_off, 3'b000};
        unique case (ld_funct3)
            3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
            3'b100:  load_ext = XLEN'(shifted[7:0]);
            3'b101:  load_ext = XLEN'(shifted[15:0]);
            3'b110:  load_ext = XLEN'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= StIdle;
            cnt        <= '0;
            ld_funct3  <= '0;
            ld_rd      <= '0;
            ld_off     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            mem_req    <= 1'b0;
            wb_en      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        if ((is_load || is_store) && !funct3_ok) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b11;
                        end else if ((is_load || is_store) && misaligned) begin
                            fault      <= 1'b1;
                            fault_code <= 2'b01;
                        end else if (is_load || is_store) begin
                            mem_req  <= 1'b1;
                            mem_we   <= is_store;
                            mem_addr <= in_addr & ~ADDR_W'(NB - 1);
                            mem_be   <= be_base << off;
                            if (is_store) begin
                                mem_wdata <= store_data;
                            end else begin
                                state     <= StLoadWait;
                                cnt       <= '0;
                                ld_funct3 <= in_funct3;
                                ld_rd     <= in_rd;
                                ld_off    <= off;
                            end
                        end else begin
                            wb_en   <= (in_rd != '0);
                            wb_rd   <= in_rd;
                            wb_data <= in_data;
                        end
                    end
                end
                StLoadWait: begin
                    cnt <= cnt + 1'b1;
                    // rvalid wins over a timeout landing on the same edge
                    if (mem_rvalid) begin
                        wb_en   <= (ld_rd != '0);
                        wb_rd   <= ld_rd;
                        wb_data <= load_ext;
                        state   <= StIdle;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage (XLEN=32): directed cases plus randomized ops against
// an arithmetic reference model of the load/store/fault rules.
module tb_mem_wb_stage;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [9:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        wb_en, fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  fault_code;

    int n_pass = 0;
    int n_total = 0;

    mem_wb_stage dut (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_addr(in_addr), .in_data(in_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Reference model
    function automatic bit m_illegal(bit ld, bit st, logic [2:0] f3);
        if (ld) return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (st) return !(f3 inside {3'd0, 3'd1, 3'd2});
        return 1'b0;
    endfunction

    function automatic int m_size(logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit m_misal(logic [2:0] f3, logic [9:0] addr);
        return (int'(addr) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [9:0] addr);
        longint v = ((longint'(1) << m_size(f3)) - 1) << (int'(addr) % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [9:0] addr, logic [31:0] d);
        longint mask = (longint'(1) << (8 * m_size(f3))) - 1;
        longint v = (longint'(d) & mask) << (8 * (int'(addr) % 4));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [9:0] addr, logic [31:0] rd);
        int bits = 8 * m_size(f3);
        longint v = (longint'(rd) >> (8 * (int'(addr) % 4))) & ((longint'(1) << bits) - 1);
        if (f3 < 4 && ((v >> (bits - 1)) & 1) == 1) v = v | ~((longint'(1) << bits) - 1);
        return v[31:0];
    endfunction

    task automatic drive_op(bit ld, bit st, logic [2:0] f3, logic [4:0] rd, logic [9:0] a,
                            logic [31:0] d);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_rd = rd; in_addr = a; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({in_ready, mem_req, wb_en, fault, fault_code, mem_be, wb_data} !== {4'b1000, 2'b00, 4'h0, 32'h0})
            $display("FAIL reset_state: got rdy=%b req=%b wb=%b flt=%b code=%b be=%h wbd=%h expected rdy=1 rest 0",
                     in_ready, mem_req, wb_en, fault, fault_code, mem_be, wb_data);
        else n_pass++;
        Reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu;
        drive_op(0, 0, 3'd0, 5'd3, 10'h0, 32'h0000_00A5);
        n_total++;
        if ({wb_en, wb_rd, wb_data, in_ready} !== {1'b1, 5'd3, 32'h0000_00A5, 1'b1})
            $display("FAIL alu_rd3: got wb_en=%b rd=%0d data=%h expected 1 3 000000a5", wb_en, wb_rd, wb_data);
        else n_pass++;
        drive_op(0, 0, 3'd0, 5'd0, 10'h0, 32'h0000_00A5);
        n_total++;
        if (wb_en !== 1'b0) $display("FAIL alu_rd0: got wb_en=%b expected 0", wb_en);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [4:0]  rd;
        logic [31:0] d;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd = 5'($urandom_range(0, 31)); d = $urandom;
            in_rd = rd; in_data = d; in_funct3 = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            n_total++;
            if (wb_en !== (rd != 0) || (rd != 0 && {wb_rd, wb_data} !== {rd, d}))
                $display("FAIL b2b_alu[%0d]: got wb_en=%b rd=%0d data=%h expected en=%b rd=%0d data=%h",
                         i, wb_en, wb_rd, wb_data, rd != 0, rd, d);
            else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_store;
        logic [2:0]  f3;
        logic [9:0]  a;
        logic [31:0] d;
        drive_op(0, 1, 3'd0, 5'd7, 10'h006, 32'h0000_00C3);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_en, fault} !==
            {2'b11, 10'h004, 4'b0100, 32'h00C3_0000, 2'b00})
            $display("FAIL store_sb: got req=%b we=%b addr=%h be=%b wdata=%h wb=%b flt=%b expected 1 1 004 0100 00c30000 0 0",
                     mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_en, fault);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom_range(0, 7)); a = 10'($urandom); d = $urandom;
            drive_op(0, 1, f3, 5'($urandom_range(1, 31)), a, d);
            n_total++;
            if (m_illegal(0, 1, f3) || m_misal(f3, a)) begin
                if ({fault, fault_code, mem_req, wb_en} !== {1'b1, m_illegal(0, 1, f3) ? 2'b11 : 2'b01, 2'b00})
                    $display("FAIL store_rand_fault[%0d]: got flt=%b code=%b req=%b wb=%b (f3=%0d addr=%h)",
                             i, fault, fault_code, mem_req, wb_en, f3, a);
                else n_pass++;
            end else if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_en, fault, in_ready} !==
                         {2'b11, a & 10'h3FC, m_be(f3, a), m_wdata(f3, a, d), 3'b001}) begin
                $display("FAIL store_rand[%0d]: got addr=%h be=%b wdata=%h expected addr=%h be=%b wdata=%h",
                         i, mem_addr, mem_be, mem_wdata, a & 10'h3FC, m_be(f3, a), m_wdata(f3, a, d));
            end else n_pass++;
        end
    endtask

    task automatic test_load_directed;
        drive_op(1, 0, 3'd0, 5'd9, 10'h001, 32'h0);
        n_total++;
        if ({mem_req, mem_we, mem_addr, mem_be, in_ready} !== {2'b10, 10'h000, 4'b0010, 1'b0})
            $display("FAIL lb_req: got req=%b we=%b addr=%h be=%b rdy=%b expected 1 0 000 0010 0",
                     mem_req, mem_we, mem_addr, mem_be, in_ready);
        else n_pass++;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_8000;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        n_total++;
        if ({wb_en, wb_rd, wb_data, in_ready} !== {1'b1, 5'd9, 32'hFFFF_FF80, 1'b1})
            $display("FAIL lb_sext: got wb=%b rd=%0d data=%h expected 1 9 ffffff80", wb_en, wb_rd, wb_data);
        else n_pass++;
        drive_op(1, 0, 3'd4, 5'd9, 10'h001, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_8000;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        n_total++;
        if ({wb_en, wb_data} !== {1'b1, 32'h0000_0080})
            $display("FAIL lbu_zext: got wb=%b data=%h expected 1 00000080", wb_en, wb_data);
        else n_pass++;
        drive_op(1, 0, 3'd2, 5'd12, 10'h008, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({in_ready, wb_en} !== 2'b00)
                $display("FAIL lw_wait[%0d]: got rdy=%b wb=%b expected 0 0", i, in_ready, wb_en);
            else n_pass++;
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        n_total++;
        if ({wb_en, wb_rd, wb_data, in_ready} !== {1'b1, 5'd12, 32'hDEAD_BEEF, 1'b1})
            $display("FAIL lw_wb: got wb=%b rd=%0d data=%h rdy=%b expected 1 12 deadbeef 1",
                     wb_en, wb_rd, wb_data, in_ready);
        else n_pass++;
    endtask

    task automatic test_faults;
        drive_op(1, 0, 3'd1, 5'd4, 10'h003, 32'h0);
        n_total++;
        if ({fault, fault_code, mem_req, wb_en, in_ready} !== {1'b1, 2'b01, 3'b001})
            $display("FAIL lh_misaligned: got flt=%b code=%b req=%b wb=%b rdy=%b expected 1 01 0 0 1",
                     fault, fault_code, mem_req, wb_en, in_ready);
        else n_pass++;
        drive_op(1, 0, 3'd3, 5'd4, 10'h003, 32'h0);
        n_total++;
        if ({fault, fault_code, mem_req} !== {1'b1, 2'b11, 1'b0})
            $display("FAIL ld_illegal: got flt=%b code=%b req=%b expected 1 11 0", fault, fault_code, mem_req);
        else n_pass++;
        drive_op(1, 0, 3'd2, 5'd4, 10'h008, 32'h0);
        for (int i = 1; i <= TMO; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (i < TMO) begin
                if ({fault, wb_en, in_ready} !== 3'b000)
                    $display("FAIL timeout_wait[%0d]: got flt=%b wb=%b rdy=%b expected 0 0 0", i, fault, wb_en, in_ready);
                else n_pass++;
            end else if ({fault, fault_code, wb_en, in_ready} !== {1'b1, 2'b10, 2'b01}) begin
                $display("FAIL timeout_fault: got flt=%b code=%b wb=%b rdy=%b expected 1 10 0 1",
                         fault, fault_code, wb_en, in_ready);
            end else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if ({fault, fault_code} !== 3'b000)
            $display("FAIL fault_pulse: got flt=%b code=%b expected 0 00", fault, fault_code);
        else n_pass++;
    endtask

    task automatic test_random_loads;
        logic [2:0]  f3;
        logic [9:0]  a;
        logic [4:0]  rd;
        logic [31:0] rdat;
        int          dly;
        bit          both;
        for (int k = 0; k < 30; k++) begin
            f3 = 3'($urandom_range(0, 7)); a = 10'($urandom); rd = 5'($urandom_range(0, 31));
            rdat = $urandom; dly = $urandom_range(1, TMO + 3); both = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) a = a & 10'h3FC;
            drive_op(1, both, f3, rd, a, $urandom);
            n_total++;
            if (m_illegal(1, 0, f3) || m_misal(f3, a)) begin
                if ({fault, fault_code, mem_req, in_ready} !== {1'b1, m_illegal(1, 0, f3) ? 2'b11 : 2'b01, 2'b01})
                    $display("FAIL load_rand_fault[%0d]: got flt=%b code=%b req=%b (f3=%0d addr=%h)",
                             k, fault, fault_code, mem_req, f3, a);
                else n_pass++;
                continue;
            end
            if ({mem_req, mem_we, mem_addr, mem_be, in_ready} !== {2'b10, a & 10'h3FC, m_be(f3, a), 1'b0})
                $display("FAIL load_rand_req[%0d]: got req=%b we=%b addr=%h be=%b expected 1 0 %h %b",
                         k, mem_req, mem_we, mem_addr, mem_be, a & 10'h3FC, m_be(f3, a));
            else n_pass++;
            for (int i = 1; i <= TMO; i++) begin
                mem_rvalid = (i == dly); mem_rdata = rdat;
                @(posedge clk); #1; mem_rvalid = 1'b0;
                if (i == dly) begin
                    n_total++;
                    if (wb_en !== (rd != 0) || fault !== 1'b0 || in_ready !== 1'b1 ||
                        (rd != 0 && {wb_rd, wb_data} !== {rd, m_load(f3, a, rdat)}))
                        $display("FAIL load_rand_wb[%0d]: got wb=%b rd=%0d data=%h flt=%b expected en=%b rd=%0d data=%h",
                                 k, wb_en, wb_rd, wb_data, fault, rd != 0, rd, m_load(f3, a, rdat));
                    else n_pass++;
                    break;
                end else if (i == TMO) begin
                    n_total++;
                    if ({fault, fault_code, wb_en, in_ready} !== {1'b1, 2'b10, 2'b01})
                        $display("FAIL load_rand_tmo[%0d]: got flt=%b code=%b wb=%b rdy=%b expected 1 10 0 1",
                                 k, fault, fault_code, wb_en, in_ready);
                    else n_pass++;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midload;
        drive_op(1, 0, 3'd2, 5'd6, 10'h010, 32'h0);
        repeat (2) @(posedge clk);
        #1; Reset = 1'b1;
        @(posedge clk); #1; Reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        n_total++;
        if ({wb_en, fault, in_ready} !== 3'b001)
            $display("FAIL reset_midload: got wb=%b flt=%b rdy=%b expected 0 0 1", wb_en, fault, in_ready);
        else n_pass++;
        drive_op(0, 0, 3'd0, 5'd5, 10'h0, 32'hCAFE_0001);
        n_total++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hCAFE_0001})
            $display("FAIL alu_after_reset: got wb=%b rd=%0d data=%h expected 1 5 cafe0001", wb_en, wb_rd, wb_data);
        else n_pass++;
    endtask

    task automatic test_rvalid_idle;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        n_total++;
        if ({wb_en, fault, mem_req} !== 3'b000)
            $display("FAIL rvalid_idle: got wb=%b flt=%b req=%b expected 0 0 0", wb_en, fault, mem_req);
        else n_pass++;
    endtask

    task automatic test_timeout_edge;
        // rvalid on the same edge the counter reaches the limit still writes back
        drive_op(1, 0, 3'd5, 5'd8, 10'h00E, 32'h0);
        repeat (TMO - 1) @(posedge clk);
        #1; mem_rvalid = 1'b1; mem_rdata = 32'h9ABC_0000;
        @(posedge clk); #1; mem_rvalid = 1'b0;
        n_total++;
        if ({wb_en, wb_data, fault} !== {1'b1, 32'h0000_9ABC, 1'b0})
            $display("FAIL rvalid_at_timeout: got wb=%b data=%h flt=%b expected 1 00009abc 0", wb_en, wb_data, fault);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store();
        test_load_directed();
        test_faults();
        test_timeout_edge();
        test_random_loads();
        test_reset_midload();
        test_rvalid_idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
